result_pipe: RTL and testbench

RESULT_PIPE -- requirements
Module: result_pipe

---
 rtl/result_pipe.sv | 136 +++++++++++++
 tb/tb_result_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_pipe.sv
// Six-slot in-order result pipeline with late load-data update, youngest-slot
// flush, and an 8x16 register file written at retirement from slot 6.
module result_pipe #(
  parameter int FLUSH_SLOTS = 2,
  parameter int LD_SLOT     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        issue_valid,
  input  logic        issue_write,
  input  logic [2:0]  issue_num,
  input  logic [15:0] issue_data,
  input  logic        ld_valid,
  input  logic [15:0] ld_data,
  output logic        m1_write,
  output logic        m2_write,
  output logic        m3_write,
  output logic        m4_write,
  output logic        m5_write,
  output logic        m6_write,
  output logic [2:0]  num_m1,
  output logic [2:0]  num_m2,
  output logic [2:0]  num_m3,
  output logic [2:0]  num_m4,
  output logic [2:0]  num_m5,
  output logic [2:0]  num_m6,
  output logic [15:0] data_m1,
  output logic [15:0] data_m2,
  output logic [15:0] data_m3,
  output logic [15:0] data_m4,
  output logic [15:0] data_m5,
  output logic [15:0] data_m6,
  input  logic [2:0]  rd_a_num,
  input  logic [2:0]  rd_b_num,
  output logic [15:0] rd_a_data,
  output logic [15:0] rd_b_data,
  output logic [15:0] retire_cnt
);

  localparam int DATA_W = 16;

  logic [6:1]        r_wr;
  logic [2:0]        r_num  [1:6];
  logic [DATA_W-1:0] r_data [1:6];
  logic [DATA_W-1:0] r_rf   [0:7];
  logic [15:0]       r_cnt;

  logic [6:1]        w_wr;
  logic [2:0]        w_num  [1:6];
  logic [DATA_W-1:0] w_data [1:6];
  logic              w_commit;
  logic              w_ld_hit;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_ld_hit = ld_valid && r_wr[LD_SLOT];
  assign w_commit = !stall && r_wr[6];

  always_comb begin
    w_wr = r_wr;
    for (int k = 1; k <= 6; k++) begin
      w_num[k]  = r_num[k];
      w_data[k] = r_data[k];
    end
    if (!stall) begin
      w_wr[1]   = issue_valid && issue_write;
      w_num[1]  = issue_num;
      w_data[1] = issue_data;
      for (int k = 2; k <= 6; k++) begin
        w_wr[k]   = r_wr[k-1];
        w_num[k]  = r_num[k-1];
        w_data[k] = r_data[k-1];
      end
      // The load result follows its instruction into the next slot.
      if (w_ld_hit) w_data[LD_SLOT+1] = ld_data;
    end else if (w_ld_hit) begin
      w_data[LD_SLOT] = ld_data;
    end
    // Flush is applied last so it overrides both issue and load update.
    if (flush) begin
      for (int k = 1; k <= 6; k++) begin
        if (k <= FLUSH_SLOTS) w_wr[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_cnt <= '0;
      for (int k = 1; k <= 6; k++) begin
        r_num[k]  <= '0;
        r_data[k] <= '0;
      end
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
    end else begin
      r_wr <= w_wr;
      for (int k = 1; k <= 6; k++) begin
        r_num[k]  <= w_num[k];
        r_data[k] <= w_data[k];
      end
      if (w_commit) begin
        r_rf[r_num[6]] <= r_data[6];
        r_cnt          <= sat_inc(r_cnt);
      end
    end
  end

  assign m1_write = r_wr[1];
  assign m2_write = r_wr[2];
  assign m3_write = r_wr[3];
  assign m4_write = r_wr[4];
  assign m5_write = r_wr[5];
  assign m6_write = r_wr[6];
  assign num_m1   = r_num[1];
  assign num_m2   = r_num[2];
  assign num_m3   = r_num[3];
  assign num_m4   = r_num[4];
  assign num_m5   = r_num[5];
  assign num_m6   = r_num[6];
  assign data_m1  = r_data[1];
  assign data_m2  = r_data[2];
  assign data_m3  = r_data[3];
  assign data_m4  = r_data[4];
  assign data_m5  = r_data[5];
  assign data_m6  = r_data[6];

  assign rd_a_data  = r_rf[rd_a_num];
  assign rd_b_data  = r_rf[rd_b_num];
  assign retire_cnt = r_cnt;

endmodule

// File: tb/tb_result_pipe.sv
// Scoreboard bench for result_pipe: the driver steps a queue-based pipeline
// model and pushes expected state; the monitor pops and compares each cycle.
module tb_result_pipe;
  localparam int FS = 2;
  localparam int LD = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic stall, flush, issue_valid, issue_write, ld_valid;
  logic [2:0] issue_num, rd_a_num, rd_b_num;
  logic [15:0] issue_data, ld_data;
  logic m1_write, m2_write, m3_write, m4_write, m5_write, m6_write;
  logic [2:0] num_m1, num_m2, num_m3, num_m4, num_m5, num_m6;
  logic [15:0] data_m1, data_m2, data_m3, data_m4, data_m5, data_m6;
  logic [15:0] rd_a_data, rd_b_data, retire_cnt;

  result_pipe #(.FLUSH_SLOTS(FS), .LD_SLOT(LD)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .issue_valid(issue_valid), .issue_write(issue_write),
    .issue_num(issue_num), .issue_data(issue_data),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .m1_write(m1_write), .m2_write(m2_write), .m3_write(m3_write),
    .m4_write(m4_write), .m5_write(m5_write), .m6_write(m6_write),
    .num_m1(num_m1), .num_m2(num_m2), .num_m3(num_m3),
    .num_m4(num_m4), .num_m5(num_m5), .num_m6(num_m6),
    .data_m1(data_m1), .data_m2(data_m2), .data_m3(data_m3),
    .data_m4(data_m4), .data_m5(data_m5), .data_m6(data_m6),
    .rd_a_num(rd_a_num), .rd_b_num(rd_b_num),
    .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        w;
    logic [2:0]  n;
    logic [15:0] d;
  } instr_t;

  typedef struct packed {
    logic [119:0] slots;
    logic [15:0]  cnt;
    logic [15:0]  rda;
    logic [15:0]  rdb;
  } snap_t;

  instr_t      pipe[$];
  logic [15:0] rf [0:7];
  logic [15:0] mcnt;
  snap_t       exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          drv_done = 1'b0;

  function automatic logic [119:0] dut_slots();
    return {m1_write, num_m1, data_m1, m2_write, num_m2, data_m2,
            m3_write, num_m3, data_m3, m4_write, num_m4, data_m4,
            m5_write, num_m5, data_m5, m6_write, num_m6, data_m6};
  endfunction

  task automatic check(input string name, input logic [119:0] act, input logic [119:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < 6; i++) pipe.push_back('0);
    for (int i = 0; i < 8; i++) rf[i] = '0;
    mcnt = '0;
  endtask

  // Applies one clock edge of the pipeline rules to the model.
  task automatic model_edge();
    instr_t old;
    if (ld_valid && pipe[LD-1].w) pipe[LD-1].d = ld_data;
    if (!stall) begin
      old = pipe.pop_back();
      if (old.w) begin
        rf[old.n] = old.d;
        if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      end
      pipe.push_front('{w: issue_valid & issue_write, n: issue_num, d: issue_data});
    end
    if (flush) for (int i = 0; i < FS; i++) pipe[i].w = 1'b0;
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.slots = '0;
    for (int i = 0; i < 6; i++) s.slots = (s.slots << 20) | 120'(pipe[i]);
    s.cnt = mcnt;
    s.rda = rf[rd_a_num];
    s.rdb = rf[rd_b_num];
    return s;
  endfunction

  task automatic set_idle();
    stall = 0; flush = 0; issue_valid = 0; issue_write = 0;
    issue_num = 0; issue_data = 0; ld_valid = 0; ld_data = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    exp_q.push_back(model_snap());
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] n, input logic [15:0] d);
    set_idle();
    issue_valid = 1; issue_write = 1; issue_num = n; issue_data = d;
    step();
  endtask

  task automatic idle(input int cycles);
    set_idle();
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_slots"}, dut_slots(), '0);
    check({tag, "_cnt"}, 120'(retire_cnt), '0);
    check({tag, "_rda"}, 120'(rd_a_data), '0);
    check({tag, "_rdb"}, 120'(rd_b_data), '0);
  endtask

  // Monitor: compare DUT state against each expected snapshot on the falling edge.
  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("slots", dut_slots(), e.slots);
        check("retire_cnt", 120'(retire_cnt), 120'(e.cnt));
        check("rd_a", 120'(rd_a_data), 120'(e.rda));
        check("rd_b", 120'(rd_b_data), 120'(e.rdb));
      end
    end
  end

  // Driver.
  initial begin
    rst_n = 0; rd_a_num = 0; rd_b_num = 0;
    set_idle();
    model_reset();
    #3;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1;
    #1;

    // Single write flows through all six slots and commits.
    rd_a_num = 3;
    issue(3, 16'h1234);
    idle(6);

    // Stall while r5 sits in slot 4.
    rd_a_num = 5;
    issue(5, 16'h5555);
    idle(3);
    set_idle(); stall = 1;
    for (int i = 0; i < 3; i++) step();
    idle(4);

    // Late load data lands in slot 3.
    rd_a_num = 2;
    issue(2, 16'h0000);
    idle(1);
    set_idle(); ld_valid = 1; ld_data = 16'hBEEF;
    step();
    idle(5);

    // Flush with four live slots, issue in the same cycle discarded.
    issue(1, 16'h0101); issue(4, 16'h0404); issue(6, 16'h0606); issue(0, 16'h0A0A);
    set_idle(); flush = 1; issue_valid = 1; issue_write = 1; issue_num = 7; issue_data = 16'hDEAD;
    step();
    idle(6);

    // Back-to-back writes to r7, last writer wins.
    rd_a_num = 7;
    issue(7, 16'h0001); issue(7, 16'h0002);
    idle(6);

    // Flush during stall and load during stall.
    issue(1, 16'h1111); issue(2, 16'h2222);
    set_idle(); stall = 1; ld_valid = 1; ld_data = 16'h7777; step();
    set_idle(); stall = 1; flush = 1; step();
    idle(6);

    // Asynchronous reset in mid-cycle with four live slots.
    issue(1, 16'hA001); issue(2, 16'hA002); issue(3, 16'hA003); issue(4, 16'hA004);
    rst_n = 0;
    #1;
    check_reset_state("midreset");
    model_reset();
    #1 rst_n = 1;
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      stall       = ($urandom_range(0, 99) < 20);
      flush       = ($urandom_range(0, 99) < 10);
      issue_valid = ($urandom_range(0, 99) < 75);
      issue_write = ($urandom_range(0, 99) < 80);
      issue_num   = 3'($urandom_range(0, 7));
      issue_data  = 16'($urandom);
      ld_valid    = ($urandom_range(0, 99) < 30);
      ld_data     = 16'($urandom);
      rd_a_num    = 3'($urandom_range(0, 7));
      rd_b_num    = 3'($urandom_range(0, 7));
      step();
    end
    idle(8);
    drv_done = 1'b1;
  end

  initial begin
    int waited;
    waited = 0;
    while (!drv_done && waited < 5000) begin
      @(posedge clk);
      waited++;
    end
    if (!drv_done) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: driver did not finish within %0d cycles", waited);
    end
    @(negedge clk); #2;
    check("queue_drained", 120'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
